// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_arb_pkg;

  localparam int unsigned FIFO_DEPTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } arb_state_t;

  typedef enum logic {
    OWNER_BOOT = 1'b0,
    OWNER_CPU  = 1'b1
  } owner_t;

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide synchronous FIFO with registered full/empty flags.
// Writes while full and reads while empty are ignored.
module byte_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW:0]   CNT_MAX = DEPTH[AW:0];
  localparam logic [AW-1:0] PTR_ONE = 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;
  logic          wr_ok;
  logic          rd_ok;

  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Next occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_nxt = count;
    case ({wr_ok, rd_ok})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

  // Storage array; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  // Pointers (wrap naturally at a power-of-two depth) and registered flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_ok) rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_nxt;
      full  <= (count_nxt == CNT_MAX);
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between a bootloader byte path (one-entry
// hold register) and a CPU byte queue, with round-robin on contention.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       boot_tx_start,
  input  logic [7:0] boot_tx_data,
  output logic       boot_busy,
  input  logic       cpu_wr_en,
  input  logic [7:0] cpu_wr_data,
  output logic       cpu_full,
  output logic       cpu_empty,
  output logic       boot_overrun,
  output logic       cpu_overrun,
  output logic       uart_tx_start,
  output logic [7:0] uart_tx_data,
  input  logic       uart_tx_busy
);

  arb_state_t state;
  owner_t     owner;
  owner_t     last_grant;
  logic       hold_valid;
  logic [7:0] hold_data;
  logic [7:0] fifo_head;
  logic       grant_boot;
  logic       grant_cpu;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_cpu_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (cpu_wr_en),
    .wr_data (cpu_wr_data),
    .rd_en   (grant_cpu),
    .rd_data (fifo_head),
    .full    (cpu_full),
    .empty   (cpu_empty)
  );

  assign boot_busy = hold_valid || ((state != ST_IDLE) && (owner == OWNER_BOOT));

  // Grant decision in IDLE: a lone requester wins, a tie goes to whoever was not granted last.
  always_comb begin
    grant_boot = (state == ST_IDLE) && hold_valid &&
                 (cpu_empty || (last_grant == OWNER_CPU));
    grant_cpu  = (state == ST_IDLE) && !cpu_empty && !grant_boot;
  end

  // Boot hold register: captures a byte only when no boot byte is held or in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else begin
      if (grant_boot) hold_valid <= 1'b0;
      if (boot_tx_start && !boot_busy) begin
        hold_valid <= 1'b1;
        hold_data  <= boot_tx_data;
      end
    end
  end

  // Sticky overrun flags for bytes dropped on either path.
  always_ff @(posedge clk) begin
    if (reset) begin
      boot_overrun <= 1'b0;
      cpu_overrun  <= 1'b0;
    end else begin
      if (boot_tx_start && boot_busy) boot_overrun <= 1'b1;
      if (cpu_wr_en && cpu_full)      cpu_overrun  <= 1'b1;
    end
  end

  // Launch FSM with registered start pulse and data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      owner         <= OWNER_CPU;
      last_grant    <= OWNER_CPU;
      uart_tx_start <= 1'b0;
      uart_tx_data  <= '0;
    end else begin
      uart_tx_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_boot) begin
            owner         <= OWNER_BOOT;
            last_grant    <= OWNER_BOOT;
            uart_tx_data  <= hold_data;
            uart_tx_start <= 1'b1;
            state         <= ST_LAUNCH;
          end else if (grant_cpu) begin
            owner         <= OWNER_CPU;
            last_grant    <= OWNER_CPU;
            uart_tx_data  <= fifo_head;
            uart_tx_start <= 1'b1;
            state         <= ST_LAUNCH;
          end
        end
        ST_LAUNCH:    state <= ST_WAIT_BUSY;
        ST_WAIT_BUSY: if (uart_tx_busy)  state <= ST_WAIT_DONE;
        ST_WAIT_DONE: if (!uart_tx_busy) state <= ST_IDLE;
        default:      state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: transaction-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_uart_tx_arbiter;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       boot_tx_start = 1'b0;
  logic [7:0] boot_tx_data = '0;
  logic       boot_busy;
  logic       cpu_wr_en = 1'b0;
  logic [7:0] cpu_wr_data = '0;
  logic       cpu_full;
  logic       cpu_empty;
  logic       boot_overrun;
  logic       cpu_overrun;
  logic       uart_tx_start;
  logic [7:0] uart_tx_data;
  logic       uart_tx_busy = 1'b0;

  uart_tx_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .boot_tx_start (boot_tx_start),
    .boot_tx_data  (boot_tx_data),
    .boot_busy     (boot_busy),
    .cpu_wr_en     (cpu_wr_en),
    .cpu_wr_data   (cpu_wr_data),
    .cpu_full      (cpu_full),
    .cpu_empty     (cpu_empty),
    .boot_overrun  (boot_overrun),
    .cpu_overrun   (cpu_overrun),
    .uart_tx_start (uart_tx_start),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_busy  (uart_tx_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // ---------------- transaction-level model ----------------
  logic [7:0] m_q[$];
  bit         m_hold_v = 0;
  logic [7:0] m_hold_d = '0;
  bit         m_tx = 0, m_tx_boot = 0, m_start = 0, m_seen = 0;
  bit         m_last_boot = 0, m_bovr = 0, m_covr = 0;
  logic [7:0] m_data = '0;

  always @(posedge clk) begin : model
    bit busy_pre, full_pre, give_boot;
    if (reset) begin
      m_q.delete();
      m_hold_v = 0; m_hold_d = '0;
      m_tx = 0; m_tx_boot = 0; m_start = 0; m_seen = 0;
      m_last_boot = 0; m_bovr = 0; m_covr = 0; m_data = '0;
    end else begin
      busy_pre = m_hold_v || (m_tx && m_tx_boot);
      full_pre = (m_q.size() == DEPTH);
      if (!m_tx) begin
        if (m_hold_v || m_q.size() > 0) begin
          give_boot = m_hold_v && (m_q.size() == 0 || !m_last_boot);
          if (give_boot) begin
            m_data = m_hold_d;
            m_hold_v = 0;
          end else begin
            m_data = m_q.pop_front();
          end
          m_tx = 1; m_tx_boot = give_boot; m_last_boot = give_boot;
          m_start = 1; m_seen = 0;
        end
      end else if (m_start) begin
        m_start = 0;
      end else if (!m_seen) begin
        if (uart_tx_busy) m_seen = 1;
      end else if (!uart_tx_busy) begin
        m_tx = 0;
      end
      if (boot_tx_start) begin
        if (busy_pre) m_bovr = 1;
        else begin m_hold_v = 1; m_hold_d = boot_tx_data; end
      end
      if (cpu_wr_en) begin
        if (full_pre) m_covr = 1;
        else m_q.push_back(cpu_wr_data);
      end
    end
  end

  // ---------------- per-cycle compare + launch log ----------------
  logic [7:0] dut_log[$];
  logic [7:0] exp_q[$];
  int         start_cyc_log[$];
  int         n_start = 0;

  always @(negedge clk) begin
    chk("tx_start",     uart_tx_start, m_start);
    chk("tx_data",      uart_tx_data,  m_data);
    chk("boot_busy",    boot_busy,     m_hold_v || (m_tx && m_tx_boot));
    chk("cpu_full",     cpu_full,      m_q.size() == DEPTH);
    chk("cpu_empty",    cpu_empty,     m_q.size() == 0);
    chk("boot_overrun", boot_overrun,  m_bovr);
    chk("cpu_overrun",  cpu_overrun,   m_covr);
    if (uart_tx_start) begin
      dut_log.push_back(uart_tx_data);
      start_cyc_log.push_back(cyc);
      n_start++;
    end
  end

  // ---------------- transmitter emulation ----------------
  int busy_len = 10;
  bit busy_hold = 0;
  bit pend = 0;
  int left = 0;

  always @(negedge clk) begin
    if (reset) begin
      uart_tx_busy = 1'b0; pend = 0; left = 0;
    end else if (uart_tx_start) begin
      pend = 1;
    end else if (pend) begin
      pend = 0; uart_tx_busy = 1'b1; left = busy_len;
    end else if (uart_tx_busy && !busy_hold) begin
      left--;
      if (left <= 0) uart_tx_busy = 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    dut_log.delete();
    start_cyc_log.delete();
  endtask

  task automatic boot(input logic [7:0] d);
    boot_tx_start = 1'b1; boot_tx_data = d;
    step();
    boot_tx_start = 1'b0;
  endtask

  task automatic cpu(input logic [7:0] d);
    cpu_wr_en = 1'b1; cpu_wr_data = d;
    step();
    cpu_wr_en = 1'b0;
  endtask

  task automatic check_log(input string name);
    chk({name, "_count"}, dut_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < dut_log.size()) chk($sformatf("%s_byte%0d", name, i), dut_log[i], exp_q[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int pulse_cyc;
    int base;
    wait_cycles(2);
    reset = 1'b0;
    chk("reset_empty", cpu_empty, 1'b1);
    chk("reset_data",  uart_tx_data, 8'h00);
    chk("reset_bbusy", boot_busy, 1'b0);

    // Single boot byte: latency, data, boot_busy lifetime
    busy_len = 10;
    pulse_cyc = cyc;
    boot(8'h5A);
    wait_cycles(4);
    chk("t35_busy_mid", boot_busy, 1'b1);
    wait_cycles(20);
    chk("t35_busy_end", boot_busy, 1'b0);
    chk("t35_nstart", start_cyc_log.size(), 1);
    if (start_cyc_log.size() > 0) chk("t35_latency", start_cyc_log[0] - pulse_cyc, 2);
    exp_q = {8'h5A};
    check_log("t35");

    // CPU queue fills while transmitter is stuck busy
    do_reset();
    busy_len = 1; busy_hold = 1;
    boot(8'hB0);
    wait_cycles(4);
    exp_q = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 5; i++) begin
      cpu_wr_en = 1'b1; cpu_wr_data = exp_q[i];
      step();
      if (i == 3) chk("t36_full_after4", cpu_full, 1'b1);
    end
    cpu_wr_en = 1'b0;
    chk("t36_overrun", cpu_overrun, 1'b1);
    busy_hold = 0;
    wait_cycles(60);
    exp_q = {8'hB0, 8'h11, 8'h22, 8'h33, 8'h44};
    check_log("t36");
    chk("t36_empty", cpu_empty, 1'b1);

    // Round-robin between simultaneous boot and CPU requests
    do_reset();
    busy_len = 3;
    boot_tx_start = 1'b1; boot_tx_data = 8'hA0;
    cpu_wr_en = 1'b1; cpu_wr_data = 8'hC0;
    step();
    boot_tx_start = 1'b0; cpu_wr_en = 1'b0;
    wait_cycles(40);
    boot_tx_start = 1'b1; boot_tx_data = 8'hA1;
    cpu_wr_en = 1'b1; cpu_wr_data = 8'hC1;
    step();
    boot_tx_start = 1'b0; cpu_wr_en = 1'b0;
    wait_cycles(40);
    cpu(8'hC2);
    cpu(8'hC3);
    boot(8'hA2);
    wait_cycles(60);
    exp_q = {8'hA0, 8'hC0, 8'hA1, 8'hC1, 8'hC2, 8'hA2, 8'hC3};
    check_log("t37");

    // Second boot pulse while first is in flight is dropped
    do_reset();
    busy_len = 5;
    boot(8'h3C);
    wait_cycles(3);
    boot(8'h3D);
    wait_cycles(30);
    chk("t38_overrun", boot_overrun, 1'b1);
    exp_q = {8'h3C};
    check_log("t38");

    // Reset while waiting for the transmitter to finish
    do_reset();
    busy_len = 1; busy_hold = 1;
    boot(8'h77);
    wait_cycles(5);
    cpu(8'h01); cpu(8'h02); cpu(8'h03);
    chk("t39_queued", cpu_empty, 1'b0);
    reset = 1'b1;
    step();
    chk("t39_empty", cpu_empty, 1'b1);
    chk("t39_start", uart_tx_start, 1'b0);
    reset = 1'b0;
    busy_hold = 0;
    base = n_start;
    wait_cycles(10);
    chk("t39_no_start", n_start - base, 0);

    // Order preserved across pointer wrap with interleaved fill/drain
    do_reset();
    busy_len = 2;
    cpu(8'h01); cpu(8'h02); cpu(8'h03);
    wait_cycles(25);
    cpu(8'h04); cpu(8'h05); cpu(8'h06);
    wait_cycles(8);
    cpu(8'h07);
    wait_cycles(25);
    cpu(8'h08); cpu(8'h09); cpu(8'h0A);
    wait_cycles(40);
    exp_q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
    check_log("t40");
    chk("t40_no_overrun", cpu_overrun, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, CPU byte-queue depth; power of two, minimum 2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 boot_tx_start  input  1  one-cycle pulse from the bootloader requesting one byte.
REQ-005 boot_tx_data  input  8  bootloader byte, valid with boot_tx_start.
REQ-006 boot_busy  output  1  high while a boot byte is held or in flight.
REQ-007 cpu_wr_en  input  1  CPU MMIO write strobe, enqueues one byte.
REQ-008 cpu_wr_data  input  8  CPU byte, valid with cpu_wr_en.
REQ-009 cpu_full  output  1  CPU queue holds FIFO_DEPTH entries.
REQ-010 cpu_empty  output  1  CPU queue holds zero entries.
REQ-011 boot_overrun  output  1  sticky: a boot byte was dropped.
REQ-012 cpu_overrun  output  1  sticky: a CPU byte was dropped.
REQ-013 uart_tx_start  output  1  one-cycle launch pulse to the UART transmitter.
REQ-014 uart_tx_data  output  8  byte presented with uart_tx_start; held stable until return to IDLE.
REQ-015 uart_tx_busy  input  1  transmitter busy flag.

Function
REQ-016 Boot path: boot_tx_start captures boot_tx_data into a one-entry hold register, valid next cycle.
REQ-017 boot_tx_start while hold register valid or boot byte in flight: byte dropped, boot_overrun set.
REQ-018 CPU path: cpu_wr_en with cpu_full low enqueues; with cpu_full high drops the byte and sets cpu_overrun.
REQ-019 cpu_full/cpu_empty are registered; simultaneous enqueue and dequeue keeps count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-020 FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
REQ-021 IDLE: if hold valid or queue non-empty, select owner, load uart_tx_data, go LAUNCH; else stay.
REQ-022 Selection: only one requester pending -> grant it; both pending -> grant the one not granted last (round-robin).
REQ-023 On grant: boot clears hold register; CPU dequeues head in the same edge.
REQ-024 LAUNCH: uart_tx_start=1 for exactly one cycle, unconditionally go WAIT_BUSY.
REQ-025 WAIT_BUSY: stay until uart_tx_busy=1, then WAIT_DONE.
REQ-026 WAIT_DONE: stay until uart_tx_busy=0, then IDLE; next launch no earlier than one cycle later.
REQ-027 Latency: boot pulse in cycle N with idle arbiter -> uart_tx_start high in cycle N+2.
REQ-028 boot_busy = hold valid OR (state != IDLE AND owner = boot).
REQ-029 uart_tx_start never high outside LAUNCH; at most one byte in flight.

Reset
REQ-030 Reset: state IDLE, hold invalid, queue empty (pointers 0), last-grant = CPU so boot wins first tie.
REQ-031 Reset outputs: uart_tx_start 0, uart_tx_data 0x00, boot_busy 0, cpu_full 0, cpu_empty 1, both overrun flags 0.
REQ-032 Reset mid-transfer abandons the in-flight byte and discards queued/held bytes; reset dominates all inputs.

Structure
REQ-033 Package uart_arb_pkg holds state enum, owner encoding (BOOT/CPU), FIFO_DEPTH default.
REQ-034 Sub-module byte_fifo (8-bit, parameterised depth, full/empty) implements the CPU queue.

Verification
REQ-035 Boot pulse 0x5A, busy returns high 1 cycle after start, 10 cycles busy -> start in N+2, data 0x5A, boot_busy low after busy falls.
REQ-036 CPU writes 0x11,0x22,0x33,0x44,0x55 back-to-back, busy never released -> cpu_full after 4th, 0x55 dropped, cpu_overrun=1.
REQ-037 Boot 0xA0 and CPU 0xC0 pending same cycle after reset -> 0xA0 sent first, then 0xC0; repeat both -> order alternates.
REQ-038 Second boot pulse while first in flight -> second dropped, boot_overrun=1, only one start pulse.
REQ-039 Reset asserted in WAIT_DONE with 3 queued bytes -> next cycle IDLE, cpu_empty=1, no start pulse after release.
REQ-040 Queue 0x01..0x0A over time with fill/drain interleaved -> output order preserved across pointer wrap.
